lab_event_buffer: RTL
=====================

// Module: lab_event_buffer
// PURPOSE
// Double-banked event buffer directly downstream of the LAB3 readout controller.
// Captures one digitized event (addr/data/wr strobes plus done pulse) into the free bank.
// Streams completed events out over a valid/ready word interface toward the host/DMA path.
// Asserts busy when both banks hold unread events, so trigger logic withholds the next hold/readout.
// PARAMETERS
// NUM_WORDS   1170   data words per event (9 ch * 260 samples / 2 clocks per word)
// ADDR_WIDTH  12     width of write address addr_i
// DATA_WIDTH  16     width of event data words
// HEADER_TAG  4'hA   tag in header word bits [15:12]
// PORTS
// clk_i        in   1   system clock; all logic on rising edge
// rst_i        in   1   synchronous, active-high reset
// wr_i         in   1   write strobe from LAB controller
// addr_i       in   12  word address within event
// dat_i        in   16  {2'b00,rco,hitbus,dat[11:0]} sample word
// done_i       in   1   1-cycle pulse: event capture complete
// busy_o       out  1   both banks full (combinational from full flags)
// overflow_o   out  1   1-cycle pulse: event dropped because no bank free
// bank_full_o  out  2   per-bank full flags
// dout_o       out  16  stream word
// dout_valid_o out  1   stream word valid
// dout_ready_i in   1   consumer accepts word when valid&ready
// dout_last_o  out  1   marks final data word of event
// BEHAVIOUR
// - Reset (rst_i=1 at edge): bank_full=0, wbank=rbank=0, event_count=0, FSM=IDLE,
//   dout_valid/last=0, dout_o=0, overflow_o=0; any stream in progress is aborted.
// - Write: wr_i & addr_i<NUM_WORDS & !full[wbank] -> RAM[wbank][addr_i]<=dat_i. addr_i>=NUM_WORDS ignored.
//   Writes to a full wbank are ignored (event being dropped).
// - done_i, full[wbank]=0: full[wbank]<=1, evnum[wbank]<=event_count, wbank toggles.
// - done_i, full[wbank]=1: overflow_o pulses the next cycle; no flag change.
// - event_count (12 b) increments on every done_i, kept or dropped; wraps 4095->0 (gaps reveal drops).
// - Same-edge done_i and bank free: done_i evaluates pre-free flags (dropped if the freed bank was wbank).
// - Read FSM: IDLE -> HDR when full[rbank]. HDR presents {HEADER_TAG, evnum[rbank]}.
//   HDR accepted -> DATA, presenting words 0..NUM_WORDS-1 in order.
//   Accepting word NUM_WORDS-1 (dout_last_o=1) clears full[rbank], toggles rbank, -> IDLE.
// - Latency: done_i sampled at edge N; dout_valid_o high after edge N+2 (header).
// - Throughput: with dout_ready_i held 1, one word per cycle header..last, no bubbles.
//   RAM has 1-cycle read latency, hidden by prefetch/skid register.
// - Hold rule: while valid & !ready, dout_o, dout_last_o, dout_valid_o stay stable.
//   dout_valid_o never drops before acceptance.
// - After last word, IDLE for >=1 cycle; dout_valid_o=0 in that cycle.
// - Per event: exactly NUM_WORDS+1 words. dout_last_o is set only on the final word.
// - busy_o = full[0]&full[1]. RAM is inferred block RAM, 2*NUM_WORDS x 16, 1 write/1 read port.
// TESTING
// T1 reset; write addr 0..1169 with dat=addr, pulse done_i; ready=1 -> header 16'hA000, then 0..1169 back-to-back,
//    last on 1169; bank_full 01->00.
// T2 two events back-to-back, ready=0 -> bank_full=11, busy_o=1; third event writes/done_i -> overflow_o 1 pulse,
//    headers A000/A001 streamed, next kept event header A003.
// T3 random dout_ready_i (50%) on a full event -> stream order/values identical to T1.
//    Outputs stable whenever valid&!ready.
// T4 rst_i mid-DATA (after 500 words) -> dout_valid_o=0 next cycle, bank_full=00; next event header A000.
// T5 writes with addr_i=1170..4095 interleaved -> ignored; streamed data matches only in-range writes.
// T6 4097 events drained continuously -> header count field wraps 4095->0, no lost/duplicated words.

Source files
------------

// File: rtl/lab_event_buffer.sv
// lab_event_buffer: double-banked capture buffer behind the LAB3 readout
// controller. One bank fills from the write strobes while the other bank
// streams out as a header word followed by NUM_WORDS data words over a
// valid/ready interface. The RAM has a one-cycle read latency. A prefetch
// register sits between the RAM and the output register so that the stream
// runs at one word per cycle with no gaps.
module lab_event_buffer #(
    parameter int         NUM_WORDS  = 1170,
    parameter int         ADDR_WIDTH = 12,
    parameter int         DATA_WIDTH = 16,
    parameter logic [3:0] HEADER_TAG = 4'hA
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  done_i,
    output logic                  busy_o,
    output logic                  overflow_o,
    output logic [1:0]            bank_full_o,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  dout_valid_o,
    input  logic                  dout_ready_i,
    output logic                  dout_last_o
);

    localparam int RAM_DEPTH = 2 * NUM_WORDS;
    localparam int RAM_AW    = $clog2(RAM_DEPTH);
    localparam int EVW       = 12;

    localparam logic [ADDR_WIDTH-1:0] NW_A       = ADDR_WIDTH'(NUM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LAST_A     = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A      = ADDR_WIDTH'(1);
    localparam logic [RAM_AW-1:0]     BANK1_BASE = RAM_AW'(NUM_WORDS);
    localparam logic [EVW-1:0]        ONE_EV     = EVW'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] ram_rd_q;

    logic [1:0]            state_q,      state_d;
    logic [1:0]            full_q,       full_d;
    logic                  wbank_q,      wbank_d;
    logic                  rbank_q,      rbank_d;
    logic [EVW-1:0]        evcnt_q,      evcnt_d;
    logic [EVW-1:0]        evnum0_q,     evnum0_d;
    logic [EVW-1:0]        evnum1_q,     evnum1_d;
    logic                  ovf_q,        ovf_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q,     rd_ptr_d;
    logic                  hdr_loaded_q, hdr_loaded_d;
    logic                  pend_q,       pend_d;
    logic                  pend_last_q,  pend_last_d;
    logic [DATA_WIDTH-1:0] dout_q,       dout_d;
    logic                  valid_q,      valid_d;
    logic                  last_q,       last_d;

    logic                  wr_en_s;
    logic [RAM_AW-1:0]     wr_idx_s;
    logic [RAM_AW-1:0]     rd_idx_s;
    logic [DATA_WIDTH-1:0] hdr_word_s;
    logic                  accept_s;
    logic                  out_free_s;
    logic                  hdr_load_s;
    logic                  move_s;
    logic                  issue_s;

    // Datapath decode: write qualification, RAM indices, and the stream handshake terms.
    always_comb begin
        wr_en_s    = wr_i && (addr_i < NW_A) && !full_q[wbank_q];
        wr_idx_s   = RAM_AW'(addr_i) + (wbank_q ? BANK1_BASE : {RAM_AW{1'b0}});
        rd_idx_s   = RAM_AW'(rd_ptr_q) + (rbank_q ? BANK1_BASE : {RAM_AW{1'b0}});
        hdr_word_s = DATA_WIDTH'({HEADER_TAG, (rbank_q ? evnum1_q : evnum0_q)});
        accept_s   = valid_q && dout_ready_i;
        out_free_s = !valid_q || dout_ready_i;
        hdr_load_s = (state_q == ST_HDR) && !hdr_loaded_q;
        // The prefetched word may advance once the header is on the output.
        move_s     = pend_q && out_free_s &&
                     ((state_q == ST_DATA) || ((state_q == ST_HDR) && hdr_loaded_q));
        // Read the next word only when the prefetch slot is empty or emptying.
        issue_s    = (state_q != ST_IDLE) && (rd_ptr_q < NW_A) && (!pend_q || move_s);
    end

    // RAM write port. No reset, so the array can map onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_q[wr_idx_s] <= dat_i;
        end
    end

    // RAM read port. It is registered, and it is read only when the prefetch slot can take the word.
    always_ff @(posedge clk_i) begin
        if (issue_s) begin
            ram_rd_q <= mem_q[rd_idx_s];
        end
    end

    // Next-state logic for the read sequencer, the prefetch slot, the output register and the capture bookkeeping.
    always_comb begin
        state_d      = state_q;
        full_d       = full_q;
        wbank_d      = wbank_q;
        rbank_d      = rbank_q;
        evcnt_d      = evcnt_q;
        evnum0_d     = evnum0_q;
        evnum1_d     = evnum1_q;
        ovf_d        = 1'b0;
        rd_ptr_d     = rd_ptr_q;
        hdr_loaded_d = hdr_loaded_q;
        pend_d       = pend_q;
        pend_last_d  = pend_last_q;
        dout_d       = dout_q;
        valid_d      = valid_q;
        last_d       = last_q;

        case (state_q)
            ST_IDLE: begin
                if (full_q[rbank_q] && !valid_q) begin
                    state_d      = ST_HDR;
                    rd_ptr_d     = {ADDR_WIDTH{1'b0}};
                    hdr_loaded_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (hdr_loaded_q && accept_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_DATA: begin
                // Acceptance of the last word releases the bank.
                if (accept_s && last_q) begin
                    state_d         = ST_IDLE;
                    full_d[rbank_q] = 1'b0;
                    rbank_d         = !rbank_q;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (issue_s) begin
            rd_ptr_d    = rd_ptr_q + ONE_A;
            pend_d      = 1'b1;
            pend_last_d = (rd_ptr_q == LAST_A);
        end else if (move_s) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        if (hdr_load_s) begin
            dout_d       = hdr_word_s;
            valid_d      = 1'b1;
            last_d       = 1'b0;
            hdr_loaded_d = 1'b1;
        end else if (move_s) begin
            dout_d  = ram_rd_q;
            valid_d = 1'b1;
            last_d  = pend_last_q;
        end else if (accept_s) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        // done_i looks at the flags from before this edge, so a bank freed on the same edge cannot take the event.
        if (done_i) begin
            evcnt_d = evcnt_q + ONE_EV;
            if (full_q[wbank_q]) begin
                ovf_d = 1'b1;
            end else begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = !wbank_q;
                if (wbank_q) begin
                    evnum1_d = evcnt_q;
                end else begin
                    evnum0_d = evcnt_q;
                end
            end
        end else begin
            evcnt_d = evcnt_q;
        end
    end

    // State registers with synchronous reset. Reset also aborts any stream in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            full_q       <= 2'b00;
            wbank_q      <= 1'b0;
            rbank_q      <= 1'b0;
            evcnt_q      <= {EVW{1'b0}};
            evnum0_q     <= {EVW{1'b0}};
            evnum1_q     <= {EVW{1'b0}};
            ovf_q        <= 1'b0;
            rd_ptr_q     <= {ADDR_WIDTH{1'b0}};
            hdr_loaded_q <= 1'b0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            dout_q       <= {DATA_WIDTH{1'b0}};
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            full_q       <= full_d;
            wbank_q      <= wbank_d;
            rbank_q      <= rbank_d;
            evcnt_q      <= evcnt_d;
            evnum0_q     <= evnum0_d;
            evnum1_q     <= evnum1_d;
            ovf_q        <= ovf_d;
            rd_ptr_q     <= rd_ptr_d;
            hdr_loaded_q <= hdr_loaded_d;
            pend_q       <= pend_d;
            pend_last_q  <= pend_last_d;
            dout_q       <= dout_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
        end
    end

    assign busy_o       = full_q[0] & full_q[1];
    assign overflow_o   = ovf_q;
    assign bank_full_o  = full_q;
    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;
    assign dout_last_o  = last_q;

endmodule
